ysyx_24080014_lsu: RTL and testbench
====================================

Name: ysyx_24080014_lsu

Overview:
- Load/store unit directly upstream of the register file.
- Takes one memory op per instruction from execute and runs it as a single AXI-Lite-style read or write transaction.
- Sign/zero-extends load data and hands the register file `load`, `mem_ready` and `rd_data` for its delayed-writeback path.
- One op in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.
- TIMEOUT_CYC, 1023, maximum cycles spent in any bus-wait state before the op is aborted with err.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  memory op presented; held by upstream until accepted.
- mem_rd  in  1  op is a load.
- mem_wr  in  1  op is a store.
- funct3  in  3  RV32 size/sign field.
- addr  in  ADDR_W  effective byte address.
- st_data  in  DATA_W  store source (rs2).
- load  out  1  memory op pending; register file must wait for mem_ready.
- mem_ready  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  extended load result.
- err  out  1  pulse coincident with mem_ready on fault.
- arvalid/arready  out/in  1  read address handshake; araddr  out  ADDR_W.
- rvalid/rready  in/out  1  read data handshake; rdata  in  DATA_W; rresp  in  2.
- awvalid/awready  out/in  1  write address handshake; awaddr  out  ADDR_W.
- wvalid/wready  out/in  1  write data handshake; wdata  out  DATA_W; wstrb  out  4.
- bvalid/bready  in/out  1  write response handshake; bresp  in  2.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all valid/ready outputs 0, mem_ready=0, err=0, rd_data=0, load=0, timeout counter=0. Reset mid-transaction drops valids immediately; no completion pulse is produced.
- accept = IDLE & ex_valid & (mem_rd|mem_wr). In the accept cycle, addr/funct3/st_data/direction are registered. ex_valid outside IDLE is ignored.
- load = accept | (state != IDLE). It deasserts the cycle after the mem_ready pulse.
- States and transitions:
  - IDLE: on accept, go to DONE(err) if illegal, else AR (load) or AW_W (store).
  - AR: arvalid=1; on arready go to R.
  - R: rready=1; on rvalid, capture the result and go to DONE.
  - AW_W: awvalid and wvalid start together and each drops independently after its own handshake; go to B once both have handshaked (same cycle allowed).
  - B: bready=1; on bvalid go to DONE.
  - DONE: mem_ready=1 (and err if flagged) for exactly one cycle, then IDLE. A new accept is possible in the cycle after DONE.
- Illegal ops (no bus access, err=1, rd_data=0, mem_ready at T+1 where T is the accept cycle):
  - mem_rd & mem_wr both set;
  - funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores;
  - misaligned address: halfword with addr[0]=1, word with addr[1:0]!=0.
- Addresses: araddr = awaddr = {addr[31:2],2'b00}, held stable while the corresponding valid is high.
- Loads: extract the byte/halfword at lane addr[1:0] from rdata.
  - funct3 000 lb: sign-extend byte.
  - 001 lh: sign-extend halfword.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend halfword.
  - rd_data is registered when rvalid&rready and held until the next accept.
- Stores:
  - sb: wdata = byte replicated ×4, wstrb = 0001<<addr[1:0].
  - sh: wdata = half replicated ×2, wstrb = 0011<<addr[1:0].
  - sw: wdata = st_data, wstrb = 1111.
- Bus errors: rresp!=0 or bresp!=0 sets err for the DONE cycle; a load then returns rd_data=0.
- Timeout: the counter resets on every state change and increments in AR/R/AW_W/B. Reaching TIMEOUT_CYC drops all valids/readies, sets err, and goes to DONE. This path is for debug only and is a protocol violation.
- Minimum latency with all slaves ready: load accept at T, arvalid T+1, rvalid T+2, mem_ready T+3. Store is the same: bvalid T+2, mem_ready T+3.

Test Plan:
- lb, addr=0x80000003, rdata=0x80123456, rresp=0, arready/rvalid immediate -> araddr=0x80000000, rd_data=0xFFFFFF80, mem_ready pulse at T+3, load high T..T+3, err=0.
- sh, addr=0x80000002, st_data=0x1234ABCD; awready delayed 3 cycles, wready immediate -> wdata=0xABCDABCD, wstrb=1100, wvalid low after 1 cycle, awvalid held 4 cycles, mem_ready one cycle after bvalid.
- lw, addr=0x80000001 -> arvalid never rises, mem_ready and err pulse at T+1, rd_data=0; next op accepted at T+2.
- lhu, addr=0x80000002, rdata=0xBEEF0000, rresp=2'b10 -> mem_ready with err=1, rd_data=0. Repeat with rresp=0 -> rd_data=0x0000BEEF.
- Store in B state, rst_n pulled low mid-cycle -> bready/load drop asynchronously, no mem_ready. After release, a fresh lbu completes normally.
- arready held low, TIMEOUT_CYC=8 -> arvalid drops after 8 cycles, mem_ready+err pulse, state IDLE.

Source files
------------

// File: rtl/ysyx_24080014_lsu.sv
// rtl/ysyx_24080014_lsu.sv - load/store unit issuing one AXI-Lite-style read or write per memory op
module ysyx_24080014_lsu #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              load,
    output logic              mem_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] op_addr;
    logic [2:0]        op_f3;
    logic [DATA_W-1:0] op_data;
    logic              op_err;
    logic              aw_done, w_done;
    logic [TW-1:0]     tcnt;
    logic              accept, legal, f3_ok, aligned, timeout, tmo_abort;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    assign accept = (state == S_IDLE) && ex_valid && (mem_rd || mem_wr);
    assign f3_ok  = mem_rd ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (funct3 inside {3'b000, 3'b001, 3'b010});
    assign aligned = (funct3[1:0] == 2'b01) ? !addr[0] :
                     (funct3[1:0] == 2'b10) ? (addr[1:0] == 2'b00) : 1'b1;
    assign legal   = !(mem_rd && mem_wr) && f3_ok && aligned;
    assign timeout = (tcnt == T_LAST);

    always_comb begin
        state_nxt = state;
        tmo_abort = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = !legal ? S_DONE : (mem_rd ? S_AR : S_AW_W);
            S_AR:   if (arready) state_nxt = S_R;
                    else if (timeout) begin state_nxt = S_DONE; tmo_abort = 1'b1; end
            S_R:    if (rvalid) state_nxt = S_DONE;
                    else if (timeout) begin state_nxt = S_DONE; tmo_abort = 1'b1; end
            S_AW_W: if ((aw_done || awready) && (w_done || wready)) state_nxt = S_B;
                    else if (timeout) begin state_nxt = S_DONE; tmo_abort = 1'b1; end
            S_B:    if (bvalid) state_nxt = S_DONE;
                    else if (timeout) begin state_nxt = S_DONE; tmo_abort = 1'b1; end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte/halfword lane selection for loads, taken from the registered address
    always_comb begin
        ld_byte = rdata[op_addr[1:0]*8 +: 8];
        ld_half = op_addr[1] ? rdata[31:16] : rdata[15:0];
        case (op_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = rdata;
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = '0;
        endcase
    end

    always_comb begin
        case (op_f3[1:0])
            2'b00: begin
                wdata = {4{op_data[7:0]}};
                wstrb = 4'b0001 << op_addr[1:0];
            end
            2'b01: begin
                wdata = {2{op_data[15:0]}};
                wstrb = 4'b0011 << op_addr[1:0];
            end
            default: begin
                wdata = op_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_addr <= '0;
            op_f3   <= '0;
            op_data <= '0;
            op_err  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tcnt    <= '0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= (state_nxt != state || state == S_IDLE || state == S_DONE) ? '0 : tcnt + 1'b1;
            if (accept) begin
                op_addr <= addr;
                op_f3   <= funct3;
                op_data <= st_data;
                op_err  <= !legal;
                rd_data <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == S_AW_W) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
            if (state == S_R && rvalid) begin
                rd_data <= (rresp != 2'b00) ? '0 : ld_ext;
                if (rresp != 2'b00) op_err <= 1'b1;
            end
            if (state == S_B && bvalid && bresp != 2'b00) op_err <= 1'b1;
            if (tmo_abort) op_err <= 1'b1;
        end
    end

    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R);
    assign awvalid   = (state == S_AW_W) && !aw_done;
    assign wvalid    = (state == S_AW_W) && !w_done;
    assign bready    = (state == S_B);
    assign araddr    = {op_addr[ADDR_W-1:2], 2'b00};
    assign awaddr    = {op_addr[ADDR_W-1:2], 2'b00};
    assign mem_ready = (state == S_DONE);
    assign err       = mem_ready && op_err;
    assign load      = accept || (state != S_IDLE);
endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// tb/tb_ysyx_24080014_lsu.sv - bench for ysyx_24080014_lsu with a delay-configurable bus slave
module tb_ysyx_24080014_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, st_data = '0;
    logic        load, mem_ready, err;
    logic [31:0] rd_data;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;

    always #5 clk = ~clk;

    ysyx_24080014_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .addr(addr), .st_data(st_data), .load(load), .mem_ready(mem_ready),
        .rd_data(rd_data), .err(err), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .awvalid(awvalid),
        .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    int n_pass = 0, n_chk = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Slave: each ready/valid answers after a programmable number of wait cycles
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    int n_ar = 0, n_aw = 0, n_w = 0, ar_hi = 0, aw_hi = 0, w_hi = 0, n_mr = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            rdata = '0; rresp = '0; bresp = '0;
            ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        end else begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            if (arvalid) begin
                ar_hi++;
                if (ar_c >= ar_dly) begin arready = 1; cap_araddr = araddr; n_ar++; ar_c = 0; end
                else ar_c++;
            end else ar_c = 0;
            if (rready) begin
                if (r_c >= r_dly) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; r_c = 0; end
                else begin r_c++; rdata = $urandom; rresp = 2'b11; end
            end else r_c = 0;
            if (awvalid) begin
                aw_hi++;
                if (aw_c >= aw_dly) begin awready = 1; cap_awaddr = awaddr; n_aw++; aw_c = 0; end
                else aw_c++;
            end else aw_c = 0;
            if (wvalid) begin
                w_hi++;
                if (w_c >= w_dly) begin wready = 1; cap_wdata = wdata; cap_wstrb = wstrb; n_w++; w_c = 0; end
                else w_c++;
            end else w_c = 0;
            if (bready) begin
                if (b_c >= b_dly) begin bvalid = 1; bresp = s_bresp; b_c = 0; end
                else begin b_c++; bresp = 2'b11; end
            end else b_c = 0;
        end
    end

    always @(negedge clk) if (mem_ready) n_mr++;

    function automatic logic legal_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (rd && wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (f3[1:0] == 2'd1 && a[0]) return 1'b0;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] sh, b, h;
        sh = word >> (8 * a[1:0]);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd2: return word;
            3'd4: return b;
            default: return h;
        endcase
    endfunction

    logic load_drop;
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output int lat, output logic got_err);
        @(negedge clk);
        ex_valid = 1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; st_data = sd;
        #1 check("load_at_accept", 32'(load), 32'd1);
        lat = -1; got_err = 1'b0; load_drop = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (mem_ready) begin lat = k; got_err = err; break; end
            if (!load) load_drop = 1'b1;
            ex_valid = 1; mem_rd = 1'($urandom); mem_wr = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; st_data = $urandom;
        end
        ex_valid = 0; mem_rd = 0; mem_wr = 0;
        check("load_held_busy", 32'(load_drop), 32'd0);
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        int lat, b_ar, b_aw, b_w, exp_lat;
        logic e, lg, exp_err;
        b_ar = n_ar; b_aw = n_aw; b_w = n_w;
        lg = legal_op(rd, wr, f3, a);
        do_op(rd, wr, f3, a, sd, lat, e);
        if (!lg) begin
            exp_lat = 1; exp_err = 1'b1;
        end else if (rd) begin
            exp_lat = 3 + ar_dly + r_dly; exp_err = (s_rresp != 2'b00);
        end else begin
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly; exp_err = (s_bresp != 2'b00);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(e), 32'(exp_err));
        if (!lg) begin
            check("illegal_no_bus", 32'(n_ar - b_ar + n_aw - b_aw), 32'd0);
            check("illegal_rd_data", rd_data, 32'd0);
        end else if (rd) begin
            check("ar_count", 32'(n_ar - b_ar), 32'd1);
            check("araddr", cap_araddr, a & ~32'd3);
            check("rd_data", rd_data, exp_err ? 32'd0 : ext_load(f3, a, s_rdata));
        end else begin
            check("aw_w_count", 32'(n_aw - b_aw + n_w - b_w), 32'd2);
            check("awaddr", cap_awaddr, a & ~32'd3);
            check("wdata", cap_wdata, (f3 == 3'd0) ? (sd & 32'hFF) * 32'h01010101 :
                                      (f3 == 3'd1) ? (sd & 32'hFFFF) * 32'h00010001 : sd);
            check("wstrb", 32'(cap_wstrb), (f3 == 3'd0) ? 32'd1 << a[1:0] :
                                           (f3 == 3'd1) ? 32'd3 << a[1:0] : 32'd15);
        end
    endtask

    initial begin
        int lat, b0, b1, mr0, sel;
        logic e, rd, wr;
        #2;
        check("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rst_outs", 32'({mem_ready, err, load}), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        @(negedge clk); rst_n = 1;

        s_rdata = 32'h80123456;
        run_op(1, 0, 3'b000, 32'h80000003, 32'h0);
        check("lb_value", rd_data, 32'hFFFFFF80);

        aw_dly = 3; b0 = aw_hi; b1 = w_hi;
        run_op(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_awvalid_cycles", 32'(aw_hi - b0), 32'd4);
        check("sh_wvalid_cycles", 32'(w_hi - b1), 32'd1);
        aw_dly = 0;

        run_op(1, 0, 3'b010, 32'h80000001, 32'h0);
        s_rdata = 32'hBEEF0000; s_rresp = 2'b10;
        run_op(1, 0, 3'b101, 32'h80000002, 32'h0);
        s_rresp = 2'b00;
        run_op(1, 0, 3'b101, 32'h80000002, 32'h0);
        check("lhu_value", rd_data, 32'h0000BEEF);
        @(negedge clk); #1 check("load_low_idle", 32'(load), 32'd0);

        // Reset asserted while the store waits in the write-response phase
        b_dly = 100;
        @(negedge clk);
        ex_valid = 1; mem_wr = 1; mem_rd = 0; funct3 = 3'b010; addr = 32'h80000020; st_data = 32'h55AA55AA;
        @(negedge clk); ex_valid = 0; mem_wr = 0;
        for (int k = 0; k < 20 && !bready; k++) @(negedge clk);
        check("rst_reached_b", 32'(bready), 32'd1);
        mr0 = n_mr;
        #2 rst_n = 0;
        #1 check("rst_async_drop", 32'({bready, load, arvalid, awvalid, wvalid}), 32'd0);
        @(negedge clk); rst_n = 1; b_dly = 0;
        @(negedge clk); #1;
        check("rst_no_mem_ready", 32'(n_mr - mr0), 32'd0);
        check("rst_load_low", 32'(load), 32'd0);
        s_rdata = 32'h00C30000;
        run_op(1, 0, 3'b100, 32'h80000002, 32'h0);

        ar_dly = 1000; b0 = ar_hi; b1 = n_ar;
        do_op(1, 0, 3'b010, 32'h80000010, 32'h0, lat, e);
        check("tmo_latency", 32'(lat), 32'd9);
        check("tmo_err", 32'(e), 32'd1);
        check("tmo_arvalid_cycles", 32'(ar_hi - b0), 32'd8);
        check("tmo_no_handshake", 32'(n_ar - b1), 32'd0);
        @(negedge clk); #1 check("tmo_idle", 32'({load, arvalid}), 32'd0);
        ar_dly = 0;

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            rd = (sel >= 1 && sel <= 4) || sel == 0;
            wr = (sel >= 5) || sel == 0;
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            s_rdata = $urandom;
            s_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_op(rd, wr, 3'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); #1 check("gap_idle", 32'({load, mem_ready}), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
